fsk_rx_deframer: RTL and testbench

//  Receive-side stage directly downstream of ultrasonicModem300k.data_out.

---
 rtl/fsk_rx_deframer.sv | 194 +++++++++++++++++++
 tb/tb_fsk_rx_deframer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_rx_deframer.sv
// Receive deframer for the demodulated FSK bit stream: input conditioning,
// async 8N1 frame recovery and a valid/ready output holding register.
module fsk_rx_deframer #(
    parameter int unsigned CLKS_PER_BIT = 10000,
    parameter int unsigned DEBOUNCE     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rx_bit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic [1:0]       sync_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic             line_q;
    logic             line_prev_q;
    logic             fall_c;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_done_c;
    logic             frame_err_c;

    // Two-flop synchroniser for the asynchronous modem output; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_bit};
        end
    end

    // Debounce: the filtered line follows only after DEBOUNCE disagreeing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q    <= '0;
            line_q      <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            line_prev_q <= line_q;
            if (sync_q[1] == line_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                line_q   <= sync_q[1];
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign fall_c = line_prev_q & ~line_q;

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

    // Frame sequencing: mid-bit sampling timed from the filtered start edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        byte_done_c = 1'b0;
        frame_err_c = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_c) begin
                        state_d = ST_START;
                        cnt_d   = HALF_BIT;
                    end
                end
                ST_START: begin
                    if (cnt_q == '0) begin
                        if (line_q) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DATA;
                            idx_d   = '0;
                            cnt_d   = FULL_BIT;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == '0) begin
                        shift_d[idx_q] = line_q;
                        cnt_d          = FULL_BIT;
                        if (idx_q == 3'd7) begin
                            state_d = ST_STOP;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == '0) begin
                        cnt_d = '0;
                        if (line_q) begin
                            byte_done_c = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            frame_err_c = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (line_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err_c;
            overrun   <= 1'b0;
            if (byte_done_c) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fsk_rx_deframer.sv
// Self-checking bench for fsk_rx_deframer with a frame-level reference model.
module tb_fsk_rx_deframer;

    localparam int unsigned CPB = 16;
    localparam int unsigned DB  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       rx_bit;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    int fe_cyc   = 0;
    int ov_cyc   = 0;
    int val_cyc  = 0;
    int busy_cyc = 0;

    fsk_rx_deframer #(.CLKS_PER_BIT(CPB), .DEBOUNCE(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rx_bit    (rx_bit),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Passive recorder: accepted bytes and pulse/level cycle counts.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) fe_cyc++;
        if (overrun) ov_cyc++;
        if (rx_valid) val_cyc++;
        if (busy) busy_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_bit = 1'b1;
        repeat (n) tick();
    endtask

    // Drive one 8N1 frame; lat = ticks from start edge until busy first seen.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int lat);
        logic [9:0] bits;
        int t;
        bits = {stop, b, 1'b0};
        lat = -1;
        t = 0;
        for (int i = 0; i < 10; i++) begin
            rx_bit = bits[i];
            for (int k = 0; k < int'(CPB); k++) begin
                tick();
                t++;
                if (lat < 0 && busy) lat = t;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; rx_bit = 1'b1; rx_ready = 1'b1;
        repeat (3) tick();
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %0h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got fe=%0b ov=%0b expected 0 0", frame_err, overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_frame_a5();
        int lat, v0, f0, o0;
        got_q.delete(); v0 = val_cyc; f0 = fe_cyc; o0 = ov_cyc;
        send_frame(8'hA5, 1'b1, lat);
        idle(20);
        checks++; if (lat != int'(DB) + 3) begin errors++; $display("FAIL a5_busy_latency: got %0d expected %0d", lat, DB + 3); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin errors++; $display("FAIL a5_data: got n=%0d first=%0h expected n=1 a5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
        checks++; if (val_cyc - v0 != 1) begin errors++; $display("FAIL a5_valid_width: got %0d expected 1", val_cyc - v0); end
        checks++; if (fe_cyc != f0 || ov_cyc != o0) begin errors++; $display("FAIL a5_flags: got fe=%0d ov=%0d expected 0 0", fe_cyc - f0, ov_cyc - o0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end: got %0b expected 0", busy); end
    endtask

    task automatic test_glitch();
        int b0, v0;
        b0 = busy_cyc; v0 = val_cyc;
        for (int i = 0; i < 6; i++) begin
            rx_bit = 1'b0;
            repeat ($urandom_range(1, DB - 1)) tick();
            idle(8);
        end
        checks++; if (busy_cyc != b0) begin errors++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_cyc - b0); end
        checks++; if (val_cyc != v0) begin errors++; $display("FAIL glitch_valid: got %0d valid cycles expected 0", val_cyc - v0); end
    endtask

    task automatic test_false_start();
        int b0, v0, f0, o0;
        b0 = busy_cyc; v0 = val_cyc; f0 = fe_cyc; o0 = ov_cyc;
        rx_bit = 1'b0;
        repeat (6) tick();
        idle(40);
        checks++; if (busy_cyc == b0) begin errors++; $display("FAIL false_start_entered: got 0 busy cycles expected >0"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_idle: got busy=%0b expected 0", busy); end
        checks++; if (val_cyc != v0 || fe_cyc != f0 || ov_cyc != o0) begin errors++; $display("FAIL false_start_quiet: got v=%0d fe=%0d ov=%0d expected 0 0 0", val_cyc - v0, fe_cyc - f0, ov_cyc - o0); end
    endtask

    task automatic test_frame_error();
        int lat, f0;
        got_q.delete(); f0 = fe_cyc;
        send_frame(8'h3C, 1'b0, lat);
        repeat (40) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_hold_busy: got %0b expected 1", busy); end
        idle(30);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release: got busy=%0b expected 0", busy); end
        send_frame(8'h81, 1'b1, lat);
        idle(20);
        checks++; if (fe_cyc - f0 != 1) begin errors++; $display("FAIL frame_err_pulses: got %0d expected 1", fe_cyc - f0); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h81) begin errors++; $display("FAIL frame_err_data: got n=%0d first=%0h expected n=1 81", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    endtask

    task automatic test_overrun();
        int lat, o0;
        got_q.delete(); o0 = ov_cyc;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, lat);
        idle(5);
        send_frame(8'h22, 1'b1, lat);
        idle(10);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL overrun_hold: got v=%0b d=%0h expected 1 11", rx_valid, rx_data); end
        checks++; if (ov_cyc - o0 != 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", ov_cyc - o0); end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_consume: got v=%0b expected 0", rx_valid); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h11) begin errors++; $display("FAIL overrun_accepted: got n=%0d expected n=1 11", got_q.size()); end
        rx_ready = 1'b1;
        idle(5);
    endtask

    task automatic test_abort();
        int lat, v0, f0, o0;
        got_q.delete(); v0 = val_cyc; f0 = fe_cyc; o0 = ov_cyc;
        fork
            send_frame(8'h5A, 1'b1, lat);
            begin
                repeat (60) tick();
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_mid_frame: got busy=%0b expected 1", busy); end
                enable = 1'b0;
                tick();
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_enable: got busy=%0b expected 0", busy); end
            end
        join
        idle(20);
        enable = 1'b1;
        idle(5);
        fork
            send_frame(8'hE7, 1'b1, lat);
            begin
                repeat (50) tick();
                rst_n = 1'b0;
                #1;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_reset: got busy=%0b expected 0", busy); end
            end
        join
        rst_n = 1'b1;
        idle(20);
        checks++; if (val_cyc != v0 || fe_cyc != f0 || ov_cyc != o0) begin errors++; $display("FAIL abort_quiet: got v=%0d fe=%0d ov=%0d expected 0 0 0", val_cyc - v0, fe_cyc - f0, ov_cyc - o0); end
        send_frame(8'hC3, 1'b1, lat);
        idle(20);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin errors++; $display("FAIL abort_recover: got n=%0d first=%0h expected n=1 c3", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    endtask

    // Random bytes, stop errors, glitches and back-to-back frames against a byte-list model.
    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic stop;
        int lat, f0, exp_fe;
        got_q.delete(); f0 = fe_cyc; exp_fe = 0;
        for (int i = 0; i < 14; i++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop, lat);
            if (stop) begin
                exp_q.push_back(b);
            end else begin
                exp_fe++;
                repeat ($urandom_range(10, 40)) tick();
                idle(25);
            end
            if ($urandom_range(0, 2) == 0) begin
                rx_bit = 1'b0;
                repeat ($urandom_range(1, DB - 1)) tick();
                idle(6);
            end
            idle($urandom_range(0, 12));
        end
        idle(20);
        checks++; if (fe_cyc - f0 != exp_fe) begin errors++; $display("FAIL random_frame_err: got %0d expected %0d", fe_cyc - f0, exp_fe); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_byte[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
